// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parameterised coin-operated vending controller with change return
module vending_machine_param #(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE     = CREDIT_W'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] ONE_UNIT  = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_UNITS = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] ZERO      = '0;

    state_t              state;
    state_t              state_next;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_next;
    logic                reject_q;
    logic                reject_next;
    logic [CREDIT_W-1:0] coin_units;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] offer_units;
    logic                coin_present;

    // Decode the inserted coin into 5-rupee units.
    always_comb begin
        coin_units = ZERO;
        case (coin)
            2'b01:   coin_units = CREDIT_W'(1);
            2'b10:   coin_units = CREDIT_W'(2);
            2'b11:   coin_units = CREDIT_W'(4);
            default: coin_units = ZERO;
        endcase
    end

    assign coin_present = (coin != 2'b00);
    assign credit_sum   = credit_q + coin_units;
    // Largest coin the hopper can pay out without overshooting the remaining credit.
    assign offer_units  = (credit_q >= TWO_UNITS) ? TWO_UNITS : ONE_UNIT;

    // State, credit and reject-pulse registers; reset beats every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= COLLECT;
            credit_q <= ZERO;
            reject_q <= 1'b0;
        end else begin
            state    <= state_next;
            credit_q <= credit_next;
            reject_q <= reject_next;
        end
    end

    // Next-state and credit arithmetic for collecting, vending and paying change.
    always_comb begin
        state_next  = state;
        credit_next = credit_q;
        reject_next = 1'b0;
        case (state)
            COLLECT: begin
                if (cancel) begin
                    // A coin arriving together with cancel is handed straight back.
                    reject_next = coin_present;
                    if (credit_q != ZERO) begin
                        state_next = CHANGE;
                    end
                end else if (coin_present) begin
                    credit_next = credit_sum;
                    if (credit_sum >= PRICE) begin
                        state_next = VEND;
                    end
                end
            end
            VEND: begin
                reject_next = coin_present;
                credit_next = credit_q - PRICE;
                if (credit_q != PRICE) begin
                    state_next = CHANGE;
                end else begin
                    state_next = COLLECT;
                end
            end
            CHANGE: begin
                reject_next = coin_present;
                if (change_ack) begin
                    credit_next = credit_q - offer_units;
                    if (credit_q == offer_units) begin
                        state_next = COLLECT;
                    end
                end
            end
            default: begin
                state_next  = COLLECT;
                credit_next = ZERO;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        dispense     = (state == VEND);
        change_valid = (state == CHANGE);
        change_coin  = 2'b00;
        if (state == CHANGE) begin
            change_coin = (credit_q >= TWO_UNITS) ? 2'b10 : 2'b01;
        end
        busy        = (state != COLLECT);
        coin_reject = reject_q;
        credit      = credit_q;
    end

endmodule
